// File: rtl/id_branch_pc_rf.sv
// id_branch_pc_rf: front-end state for the 5-stage MIPS core.
// Holds the fetch PC, the 32x32 GPR file with write-first bypass, and the
// ID-stage branch-condition evaluator that works on forwarded rs/rt values.

// Fetch PC register: reset > stall > load NPC. No alignment enforcement.
module id_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] NPC,
  output logic [31:0] PC
);

  // Synchronous active-low reset; stall freezes the fetch address.
  always_ff @(posedge clk) begin
    if (!rst)       PC <= RESET_PC;
    else if (!stall) PC <= NPC;
  end

endmodule

// One combinational read port with write-first bypass from the WB stage.
module id_rf_rd_port (
  input  logic [31:0][31:0] regs,
  input  logic [4:0]        addr,
  input  logic              wr_en,
  input  logic [4:0]        wr_sel,
  input  logic [31:0]       wr_data,
  output logic [31:0]       data
);

  // r0 is hardwired to zero; a same-cycle WB write to addr wins over the array.
  always_comb begin
    data = regs[addr];
    if (addr == 5'd0)
      data = '0;
    else if (wr_en && (wr_sel == addr))
      data = wr_data;
  end

endmodule

// 32x32 register file, NUM_RD combinational read ports, one write port.
module id_reg_file #(
  parameter int NUM_RD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0][4:0]        rd_addr,
  output logic [NUM_RD-1:0][31:0]       rd_data,
  input  logic                          RFWr,
  input  logic [4:0]                    WBSel,
  input  logic [31:0]                   WD
);

  logic [31:0][31:0] regs;
  logic              wr_en;

  // Writes to r0 are dropped so it never holds anything but zero.
  assign wr_en = RFWr && (WBSel != 5'd0);

  // Reset clears the whole array and takes priority over a write.
  always_ff @(posedge clk) begin
    if (!rst)       regs <= '0;
    else if (wr_en) regs[WBSel] <= WD;
  end

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      id_rf_rd_port u_port (
        .regs    (regs),
        .addr    (rd_addr[p]),
        .wr_en   (wr_en),
        .wr_sel  (WBSel),
        .wr_data (WD),
        .data    (rd_data[p])
      );
    end
  endgenerate

endmodule

// ID-stage branch condition on forwarded operands; purely combinational.
module id_branch_eval (
  input  logic [31:0] rsv,
  input  logic [31:0] rtv,
  input  logic [5:0]  Op,
  input  logic [4:0]  rt,
  output logic        branch_taken
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic neg, zero, pos, eq;

  // Sign classification from bit 31 plus a zero test; no subtractor needed.
  assign neg  = rsv[31];
  assign zero = (rsv == 32'd0);
  assign pos  = !neg && !zero;
  assign eq   = (rsv == rtv);

  // Decode opcode / REGIMM sub-opcode into the taken condition.
  always_comb begin
    branch_taken = 1'b0;
    case (Op)
      OP_BEQ:  branch_taken = eq;
      OP_BNE:  branch_taken = !eq;
      OP_BLEZ: branch_taken = neg || zero;
      OP_BGTZ: branch_taken = pos;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: branch_taken = neg;
          RT_BGEZ, RT_BGEZAL: branch_taken = !neg;
          default:            branch_taken = 1'b0;
        endcase
      end
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// Top: wires PC, register file and branch evaluator together.
module id_branch_pc_rf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] NPC,
  output logic [31:0] PC,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic        RFWr,
  input  logic [4:0]  WBSel,
  input  logic [31:0] WD,
  input  logic [31:0] rsv,
  input  logic [31:0] rtv,
  input  logic [5:0]  Op,
  input  logic [4:0]  rt,
  output logic        branch_taken
);

  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;

  assign rd_addr = {A2, A1};
  assign RD1     = rd_data[0];
  assign RD2     = rd_data[1];

  id_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .NPC   (NPC),
    .PC    (PC)
  );

  id_reg_file #(.NUM_RD(2)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .RFWr    (RFWr),
    .WBSel   (WBSel),
    .WD      (WD)
  );

  id_branch_eval u_br (
    .rsv          (rsv),
    .rtv          (rtv),
    .Op           (Op),
    .rt           (rt),
    .branch_taken (branch_taken)
  );

endmodule

// File: tb/tb_id_branch_pc_rf.sv
// Bench for id_branch_pc_rf: directed plan followed by random traffic,
// all checked against a behavioural model (array RF, PC variable, signed
// compares for the branch rules).
module tb_id_branch_pc_rf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] NPC = '0;
  logic [31:0] PC;
  logic [4:0]  A1 = '0, A2 = '0;
  logic [31:0] RD1, RD2;
  logic        RFWr = 1'b0;
  logic [4:0]  WBSel = '0;
  logic [31:0] WD = '0;
  logic [31:0] rsv = '0, rtv = '0;
  logic [5:0]  Op = '0;
  logic [4:0]  rt = '0;
  logic        branch_taken;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  id_branch_pc_rf #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .NPC(NPC), .PC(PC),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RFWr(RFWr), .WBSel(WBSel), .WD(WD),
    .rsv(rsv), .rtv(rtv), .Op(Op), .rt(rt),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RFWr && WBSel == a) return WD;
    return m_rf[a];
  endfunction

  function automatic logic m_br();
    case (Op)
      6'd4: return rsv == rtv;
      6'd5: return rsv != rtv;
      6'd6: return $signed(rsv) <= 0;
      6'd7: return $signed(rsv) > 0;
      6'd1: begin
        if (rt == 5'd0 || rt == 5'd16) return $signed(rsv) < 0;
        if (rt == 5'd1 || rt == 5'd17) return $signed(rsv) >= 0;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check combinational outputs mid-cycle, then the edge result.
  task automatic cycle();
    @(negedge clk);
    if (m_valid) begin
      chk("RD1", RD1, m_rd(A1));
      chk("RD2", RD2, m_rd(A2));
    end
    chk("BR", {31'b0, branch_taken}, {31'b0, m_br()});
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_valid = 1'b1;
    end else begin
      if (!stall) m_pc = NPC;
      if (RFWr && WBSel != 0) m_rf[WBSel] = WD;
    end
    #1;
    if (m_valid) chk("PC", PC, m_pc);
  endtask

  task automatic br_case(input string tag, input logic [5:0] op, input logic [4:0] rtf,
                         input logic [31:0] s, input logic [31:0] t, input logic exp);
    Op = op; rt = rtf; rsv = s; rtv = t;
    #1;
    chk(tag, {31'b0, branch_taken}, {31'b0, exp});
    cycle();
  endtask

  initial begin
    logic [31:0] corner [5];
    logic [5:0]  ops [8];
    logic [4:0]  rts [6];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    ops    = '{6'd0, 6'd1, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'h23};
    rts    = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd17, 5'd31};

    // Reset and PC stepping
    rst = 0; NPC = 32'h100;
    cycle(); cycle();
    chk("pc_reset", PC, 32'h0);
    rst = 1; stall = 0;
    NPC = 32'h4; cycle(); chk("pc_4", PC, 32'h4);
    NPC = 32'h8; cycle(); chk("pc_8", PC, 32'h8);
    NPC = 32'hC; cycle(); chk("pc_c", PC, 32'hC);
    stall = 1; NPC = 32'h100; cycle(); chk("pc_stall", PC, 32'hC);
    rst = 0; cycle(); chk("pc_stall_rst", PC, 32'h0);
    rst = 1; stall = 0;

    // RF write/read
    RFWr = 1; WBSel = 5; WD = 32'hDEAD_BEEF; cycle();
    RFWr = 0; A1 = 5; #1; chk("rf_r5", RD1, 32'hDEAD_BEEF); cycle();
    RFWr = 1; WBSel = 0; WD = 32'h1234; A1 = 0; cycle();
    RFWr = 0; #1; chk("rf_r0", RD1, 32'h0); cycle();
    rst = 0; cycle(); rst = 1;
    A1 = 5; #1; chk("rf_r5_rst", RD1, 32'h0); cycle();

    // Bypass
    RFWr = 1; WBSel = 7; WD = 32'hA5A5_A5A5; A1 = 7; A2 = 7; #1;
    chk("byp_rd1", RD1, 32'hA5A5_A5A5);
    chk("byp_rd2", RD2, 32'hA5A5_A5A5);
    cycle();
    RFWr = 0;

    // Branches
    br_case("beq_eq",   6'd4, 5'd0, 32'h10, 32'h10, 1'b1);
    br_case("bne_eq",   6'd5, 5'd0, 32'h10, 32'h10, 1'b0);
    br_case("bne_ne",   6'd5, 5'd0, 32'h1,  32'h2,  1'b1);
    br_case("blez_m1",  6'd6, 5'd0, 32'hFFFF_FFFF, 0, 1'b1);
    br_case("bgtz_m1",  6'd7, 5'd0, 32'hFFFF_FFFF, 0, 1'b0);
    br_case("bltz_m1",  6'd1, 5'd0, 32'hFFFF_FFFF, 0, 1'b1);
    br_case("bgez_m1",  6'd1, 5'd1, 32'hFFFF_FFFF, 0, 1'b0);
    br_case("blez_0",   6'd6, 5'd0, 32'h0, 0, 1'b1);
    br_case("bgez_0",   6'd1, 5'd1, 32'h0, 0, 1'b1);
    br_case("bgtz_0",   6'd7, 5'd0, 32'h0, 0, 1'b0);
    br_case("bltz_0",   6'd1, 5'd0, 32'h0, 0, 1'b0);
    br_case("bgtz_max", 6'd7, 5'd0, 32'h7FFF_FFFF, 0, 1'b1);
    br_case("bltz_min", 6'd1, 5'd16, 32'h8000_0000, 0, 1'b1);
    br_case("bgezal_min", 6'd1, 5'd17, 32'h8000_0000, 0, 1'b0);
    br_case("nb_op0",   6'd0,  5'd0, 32'h5, 32'h5, 1'b0);
    br_case("nb_lw",    6'h23, 5'd0, 32'h5, 32'h5, 1'b0);
    br_case("nb_rt2",   6'd1,  5'd2, 32'h5, 32'h5, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 3) == 0);
      NPC   = $urandom;
      RFWr  = $urandom_range(0, 1);
      WBSel = $urandom_range(0, 31);
      WD    = $urandom;
      A1    = ($urandom_range(0, 3) == 0) ? WBSel : 5'($urandom_range(0, 31));
      A2    = ($urandom_range(0, 3) == 0) ? WBSel : 5'($urandom_range(0, 31));
      rsv   = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rtv   = ($urandom_range(0, 2) == 0) ? rsv : $urandom;
      Op    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      rt    = rts[$urandom_range(0, 5)];
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
